// File: rtl/mac_pkg.sv
// Shared MAC address types and the XOR fold used to build learning-table indices.
package mac_pkg;

  localparam int unsigned MAC_BYTES = 6;
  localparam int unsigned HDR_BYTES = 12;
  localparam int unsigned MAC_W     = 8 * MAC_BYTES;
  localparam int unsigned HDR_W     = 8 * HDR_BYTES;

  typedef logic [MAC_W-1:0] mac_t;

  // Bit i of the address lands in index bit (i mod width); upper chunk is implicitly zero-padded.
  function automatic mac_t mac_fold(input mac_t addr, input int unsigned width);
    mac_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MAC_W; i++) begin
      idx[6'(i % width)] = idx[6'(i % width)] ^ addr[6'(i)];
    end
    return idx;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mac_hdr_hash.sv
// Captures DA/SA from each ingress frame, folds them to table indices and issues
// one valid/ready request per frame; requests arriving while the table stalls are dropped.
module mac_hdr_hash
  import mac_pkg::*;
#(
  parameter int unsigned pNUM_PORTS  = 4,
  parameter int unsigned pADDR_WIDTH = 14,
  parameter int unsigned pCNT_WIDTH  = 16
) (
  input  logic                          iclk,
  input  logic                          irst_n,
  input  logic                          ivalid,
  input  logic                          isof,
  input  logic                          ieof,
  input  logic [7:0]                    idata,
  input  logic [$clog2(pNUM_PORTS)-1:0] ipnum,
  output logic                          ovalid,
  input  logic                          iready,
  output logic [$clog2(pNUM_PORTS)-1:0] opnum,
  output logic [pADDR_WIDTH-1:0]        osa,
  output logic [pADDR_WIDTH-1:0]        oda,
  output logic                          omcast,
  output logic [pCNT_WIDTH-1:0]         odrop_cnt,
  output logic [pCNT_WIDTH-1:0]         orunt_cnt
);

  localparam int unsigned PORT_W = $clog2(pNUM_PORTS);
  localparam int unsigned BCNT_W = $clog2(HDR_BYTES + 1);
  localparam int unsigned HOLD_W = HDR_W - 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;

  logic [1:0]             state_q,    state_d;
  logic [BCNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [HOLD_W-1:0]      hdr_q,      hdr_d;
  logic [PORT_W-1:0]      pnum_q,     pnum_d;

  logic                   res_valid_q, res_valid_d;
  logic [PORT_W-1:0]      res_pnum_q,  res_pnum_d;
  logic [pADDR_WIDTH-1:0] res_sa_q,    res_sa_d;
  logic [pADDR_WIDTH-1:0] res_da_q,    res_da_d;
  logic                   res_mcast_q, res_mcast_d;

  logic                   ovalid_q,    ovalid_d;
  logic [PORT_W-1:0]      opnum_q,     opnum_d;
  logic [pADDR_WIDTH-1:0] osa_q,       osa_d;
  logic [pADDR_WIDTH-1:0] oda_q,       oda_d;
  logic                   omcast_q,    omcast_d;

  logic [HDR_W-1:0]       hdr_shift_c;
  mac_t                   da_c;
  mac_t                   sa_c;
  logic                   hdr_done_c;
  logic                   runt_inc_c;
  logic                   load_c;
  logic                   drop_inc_c;

  // Only 11 bytes are stored; the 12th is folded straight from the input bus.
  assign hdr_shift_c = {hdr_q, idata};
  assign da_c        = hdr_shift_c[HDR_W-1 -: MAC_W];
  assign sa_c        = hdr_shift_c[MAC_W-1:0];

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_d      = hdr_q;
    pnum_d     = pnum_q;
    hdr_done_c = 1'b0;
    runt_inc_c = 1'b0;
    if (ivalid) begin
      if (isof) begin
        // Restart from any state; an abandoned header or a one-byte frame is a runt.
        runt_inc_c = (state_q == ST_HDR) || ieof;
        hdr_d      = hdr_shift_c[HOLD_W-1:0];
        pnum_d     = ipnum;
        byte_cnt_d = BCNT_W'(1);
        state_d    = ieof ? ST_IDLE : ST_HDR;
      end else begin
        case (state_q)
          ST_HDR: begin
            hdr_d      = hdr_shift_c[HOLD_W-1:0];
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            if (byte_cnt_q == BCNT_W'(HDR_BYTES - 1)) begin
              hdr_done_c = 1'b1;
              state_d    = ieof ? ST_IDLE : ST_SKIP;
            end else if (ieof) begin
              runt_inc_c = 1'b1;
              state_d    = ST_IDLE;
            end
          end
          ST_SKIP: begin
            if (ieof) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Fold stage: one-cycle result register fed from the completed header.
  always_comb begin
    res_valid_d = hdr_done_c;
    res_pnum_d  = res_pnum_q;
    res_sa_d    = res_sa_q;
    res_da_d    = res_da_q;
    res_mcast_d = res_mcast_q;
    if (hdr_done_c) begin
      res_pnum_d  = pnum_q;
      res_sa_d    = pADDR_WIDTH'(mac_fold(sa_c, pADDR_WIDTH));
      res_da_d    = pADDR_WIDTH'(mac_fold(da_c, pADDR_WIDTH));
      res_mcast_d = da_c[40];
    end
  end

  // Output stage: a new result loads when the slot is empty or being accepted this cycle.
  assign load_c     = res_valid_q && (!ovalid_q || iready);
  assign drop_inc_c = res_valid_q && ovalid_q && !iready;

  always_comb begin
    ovalid_d = ovalid_q;
    opnum_d  = opnum_q;
    osa_d    = osa_q;
    oda_d    = oda_q;
    omcast_d = omcast_q;
    if (load_c) begin
      ovalid_d = 1'b1;
      opnum_d  = res_pnum_q;
      osa_d    = res_sa_q;
      oda_d    = res_da_q;
      omcast_d = res_mcast_q;
    end else if (ovalid_q && iready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      hdr_q       <= '0;
      pnum_q      <= '0;
      res_valid_q <= 1'b0;
      res_pnum_q  <= '0;
      res_sa_q    <= '0;
      res_da_q    <= '0;
      res_mcast_q <= 1'b0;
      ovalid_q    <= 1'b0;
      opnum_q     <= '0;
      osa_q       <= '0;
      oda_q       <= '0;
      omcast_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      hdr_q       <= hdr_d;
      pnum_q      <= pnum_d;
      res_valid_q <= res_valid_d;
      res_pnum_q  <= res_pnum_d;
      res_sa_q    <= res_sa_d;
      res_da_q    <= res_da_d;
      res_mcast_q <= res_mcast_d;
      ovalid_q    <= ovalid_d;
      opnum_q     <= opnum_d;
      osa_q       <= osa_d;
      oda_q       <= oda_d;
      omcast_q    <= omcast_d;
    end
  end

  sat_cnt #(.WIDTH(pCNT_WIDTH)) u_drop_cnt (
    .clk     (iclk),
    .rst_n   (irst_n),
    .inc_i   (drop_inc_c),
    .clear_i (1'b0),
    .count_o (odrop_cnt)
  );

  sat_cnt #(.WIDTH(pCNT_WIDTH)) u_runt_cnt (
    .clk     (iclk),
    .rst_n   (irst_n),
    .inc_i   (runt_inc_c),
    .clear_i (1'b0),
    .count_o (orunt_cnt)
  );

  assign ovalid = ovalid_q;
  assign opnum  = opnum_q;
  assign osa    = osa_q;
  assign oda    = oda_q;
  assign omcast = omcast_q;

endmodule

// File: tb/tb_mac_hdr_hash.sv
// Directed and randomized frames against a frame-level reference model of mac_hdr_hash.
module tb_mac_hdr_hash;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 14;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = 2;

  logic          iclk = 1'b0;
  logic          irst_n;
  logic          ivalid, isof, ieof, iready;
  logic [7:0]    idata;
  logic [PW-1:0] ipnum;
  logic          ovalid, omcast;
  logic [PW-1:0] opnum;
  logic [AW-1:0] osa, oda;
  logic [CW-1:0] odrop_cnt, orunt_cnt;

  always #5 iclk = ~iclk;

  mac_hdr_hash #(.pNUM_PORTS(NP), .pADDR_WIDTH(AW), .pCNT_WIDTH(CW)) dut (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .isof(isof), .ieof(ieof),
    .idata(idata), .ipnum(ipnum), .ovalid(ovalid), .iready(iready), .opnum(opnum),
    .osa(osa), .oda(oda), .omcast(omcast), .odrop_cnt(odrop_cnt), .orunt_cnt(orunt_cnt)
  );

  typedef struct {
    logic [PW-1:0] pnum;
    logic [AW-1:0] sa;
    logic [AW-1:0] da;
    logic          mc;
    int            t;
  } req_t;

  req_t pend[$];
  req_t exp_r;
  req_t done_req;
  logic exp_valid;
  logic done_now, runt_now;
  int   checks, errors, edge_n;
  int   exp_drop, exp_runt;
  int   ready_mode;
  bit   open_short;
  int   hi_cnt;
  logic [AW-1:0] seen_da, seen_sa;
  logic [PW-1:0] seen_pnum;
  logic          seen_mc;

  // Reference fold: XOR of 14-bit chunks taken with plain shifts.
  function automatic logic [AW-1:0] ref_fold(input logic [47:0] a);
    logic [47:0] x;
    x = a ^ (a >> 14) ^ (a >> 28) ^ (a >> 42);
    return x[AW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic accept;
    req_t r;
    case (ready_mode)
      0:       iready = 1'b1;
      2:       iready = 1'b0;
      default: iready = 1'($urandom_range(0, 1));
    endcase
    @(posedge iclk);
    edge_n++;
    accept = exp_valid && iready;
    if (pend.size() > 0 && pend[0].t == edge_n) begin
      r = pend.pop_front();
      if (!exp_valid || accept) begin
        exp_r     = r;
        exp_valid = 1'b1;
      end else if (exp_drop < 65535) begin
        exp_drop++;
      end
    end else if (accept) begin
      exp_valid = 1'b0;
    end
    if (done_now) begin
      r   = done_req;
      r.t = edge_n + 1;
      pend.push_back(r);
    end
    if (runt_now && exp_runt < 65535) exp_runt++;
    #1;
    chk("ovalid", 64'(ovalid), 64'(exp_valid));
    if (exp_valid) begin
      chk("opnum", 64'(opnum), 64'(exp_r.pnum));
      chk("osa", 64'(osa), 64'(exp_r.sa));
      chk("oda", 64'(oda), 64'(exp_r.da));
      chk("omcast", 64'(omcast), 64'(exp_r.mc));
    end
    chk("drop_cnt", 64'(odrop_cnt), 64'(exp_drop));
    chk("runt_cnt", 64'(orunt_cnt), 64'(exp_runt));
    if (ovalid) begin
      hi_cnt++;
      seen_da   = oda;
      seen_sa   = osa;
      seen_pnum = opnum;
      seen_mc   = omcast;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ivalid = 1'b0; isof = 1'($urandom_range(0, 1)); ieof = 1'($urandom_range(0, 1));
      idata = 8'($urandom); ipnum = 2'($urandom);
      tick();
    end
    isof = 1'b0; ieof = 1'b0;
  endtask

  // Valid bytes with no isof; the DUT must be idle and ignore them.
  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      ivalid = 1'b1; isof = 1'b0; ieof = 1'($urandom_range(0, 1));
      idata = 8'($urandom); ipnum = 2'($urandom);
      tick();
    end
    ivalid = 1'b0; ieof = 1'b0;
  endtask

  task automatic send_frame(input logic [PW-1:0] pn, input logic [47:0] da, input logic [47:0] sa,
                            input int len, input bit cut, input int gap);
    logic [95:0] hdr;
    hdr = {da, sa};
    for (int k = 0; k < len; k++) begin
      if (gap == 1 && k > 0) idle(1);
      else if (gap == 2) idle($urandom_range(0, 2));
      ivalid = 1'b1;
      isof   = (k == 0);
      ieof   = (k == len - 1) && !cut;
      if (k < 12) idata = 8'(hdr >> (8 * (11 - k)));
      else        idata = 8'($urandom);
      ipnum    = (k == 0) ? pn : 2'($urandom);
      runt_now = (k == 0 && open_short) || (ieof && k < 11);
      done_now = (k == 11);
      done_req = '{pnum: pn, sa: ref_fold(sa), da: ref_fold(da), mc: da[40], t: 0};
      tick();
      ivalid = 1'b0; isof = 1'b0; ieof = 1'b0;
      runt_now = 1'b0; done_now = 1'b0;
    end
    open_short = cut && (len < 12);
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear immediately.
  task automatic do_reset();
    ivalid = 1'b0; isof = 1'b0; ieof = 1'b0;
    irst_n = 1'b0;
    #2;
    chk("rst_ovalid", 64'(ovalid), 64'(0));
    chk("rst_opnum", 64'(opnum), 64'(0));
    chk("rst_osa", 64'(osa), 64'(0));
    chk("rst_oda", 64'(oda), 64'(0));
    chk("rst_omcast", 64'(omcast), 64'(0));
    chk("rst_drop", 64'(odrop_cnt), 64'(0));
    chk("rst_runt", 64'(orunt_cnt), 64'(0));
    @(posedge iclk);
    #1;
    irst_n = 1'b1;
    pend.delete();
    exp_valid = 1'b0; exp_drop = 0; exp_runt = 0; open_short = 1'b0;
  endtask

  initial begin
    logic [47:0] da1, sa1, da2, sa2;
    int len, gap;
    bit cut;
    checks = 0; errors = 0; edge_n = 0; exp_drop = 0; exp_runt = 0;
    exp_valid = 1'b0; done_now = 1'b0; runt_now = 1'b0; open_short = 1'b0;
    ready_mode = 0; hi_cnt = 0;
    seen_da = '0; seen_sa = '0; seen_pnum = '0; seen_mc = 1'b0;
    irst_n = 1'b0; ivalid = 1'b0; isof = 1'b0; ieof = 1'b0;
    idata = '0; ipnum = '0; iready = 1'b1;
    @(posedge iclk);
    #1;
    do_reset();

    // Bytes before the first isof, then a plain unicast frame.
    junk(5);
    hi_cnt = 0;
    send_frame(2'd2, 48'h0000_0000_0001, 48'h0000_0000_4000, 64, 1'b0, 0);
    idle(4);
    chk("t1_pulses", 64'(hi_cnt), 64'(1));
    chk("t1_opnum", 64'(seen_pnum), 64'(2));
    chk("t1_oda", 64'(seen_da), 64'h0001);
    chk("t1_osa", 64'(seen_sa), 64'h0001);
    chk("t1_mcast", 64'(seen_mc), 64'(0));

    do_reset();
    hi_cnt = 0;
    send_frame(2'd1, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0000, 20, 1'b0, 1);
    idle(4);
    chk("t2_pulses", 64'(hi_cnt), 64'(1));
    chk("t2_oda", 64'(seen_da), 64'h3FC0);
    chk("t2_osa", 64'(seen_sa), 64'h2000);
    chk("t2_mcast", 64'(seen_mc), 64'(1));

    do_reset();
    hi_cnt = 0;
    send_frame(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 7, 1'b0, 0);
    idle(4);
    chk("t3_runt", 64'(orunt_cnt), 64'(1));
    chk("t3_noreq", 64'(hi_cnt), 64'(0));
    da1 = {$urandom, $urandom};
    send_frame(2'd3, da1, {$urandom, $urandom}, 20, 1'b0, 0);
    idle(4);
    chk("t3_good", 64'(hi_cnt), 64'(1));
    chk("t3_oda", 64'(seen_da), 64'(ref_fold(da1)));

    // Table stalled across two back-to-back frames.
    do_reset();
    ready_mode = 2;
    da1 = {$urandom, $urandom}; sa1 = {$urandom, $urandom};
    da2 = {$urandom, $urandom}; sa2 = {$urandom, $urandom};
    send_frame(2'd1, da1, sa1, 14, 1'b0, 0);
    send_frame(2'd2, da2, sa2, 14, 1'b0, 0);
    idle(3);
    chk("t4_drop", 64'(odrop_cnt), 64'(1));
    chk("t4_held", 64'(ovalid), 64'(1));
    chk("t4_oda", 64'(oda), 64'(ref_fold(da1)));
    chk("t4_osa", 64'(osa), 64'(ref_fold(sa1)));
    ready_mode = 0;
    idle(1);
    chk("t4_released", 64'(ovalid), 64'(0));

    do_reset();
    hi_cnt = 0;
    da2 = {$urandom, $urandom}; sa2 = {$urandom, $urandom};
    send_frame(2'd3, {$urandom, $urandom}, {$urandom, $urandom}, 5, 1'b1, 0);
    send_frame(2'd3, da2, sa2, 16, 1'b0, 0);
    idle(4);
    chk("t5_runt", 64'(orunt_cnt), 64'(1));
    chk("t5_pulses", 64'(hi_cnt), 64'(1));
    chk("t5_oda", 64'(seen_da), 64'(ref_fold(da2)));
    chk("t5_osa", 64'(seen_sa), 64'(ref_fold(sa2)));

    // Reset while a request is held and a frame is half received.
    do_reset();
    ready_mode = 2;
    send_frame(2'd1, {$urandom, $urandom}, {$urandom, $urandom}, 20, 1'b0, 0);
    idle(3);
    chk("t6_held", 64'(ovalid), 64'(1));
    send_frame(2'd1, {$urandom, $urandom}, {$urandom, $urandom}, 6, 1'b1, 0);
    do_reset();
    ready_mode = 0;
    junk(8);
    hi_cnt = 0;
    da1 = {$urandom, $urandom};
    send_frame(2'd2, da1, {$urandom, $urandom}, 15, 1'b0, 0);
    idle(4);
    chk("t6_pulses", 64'(hi_cnt), 64'(1));
    chk("t6_oda", 64'(seen_da), 64'(ref_fold(da1)));
    chk("t6_runt", 64'(orunt_cnt), 64'(0));

    // Randomized traffic with random backpressure, gaps, runts and abandoned frames.
    do_reset();
    for (int f = 0; f < 80; f++) begin
      ready_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      len = ($urandom_range(0, 9) == 0) ? 64 : $urandom_range(1, 20);
      if (open_short && len < 2) len = 2;
      cut = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 2);
      da1 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) da1[40] = 1'b1;
      send_frame(2'($urandom), da1, {$urandom, $urandom}, len, cut, gap);
      idle($urandom_range(0, 3));
    end
    ready_mode = 0;
    idle(6);
    chk("final_drained", 64'(pend.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_hdr_hash.md
Name: mac_hdr_hash

Overview:
Ingress-side stage directly upstream of the MAC learning table. It consumes a per-frame byte stream tagged with the ingress port number and captures the 6-byte destination and 6-byte source MAC addresses. It folds each address to a pADDR_WIDTH-bit table index and presents one lookup/learn request per frame to the MAC table over a valid/ready handshake.

Parameters:
pNUM_PORTS, 4, number of switch ports; port field width is $clog2(pNUM_PORTS)
pADDR_WIDTH, 14, MAC table index width; hash output width
pCNT_WIDTH, 16, width of the saturating drop and runt counters

Ports:
iclk  in  1  clock
irst_n  in  1  asynchronous active-low reset
ivalid  in  1  byte strobe; gaps with ivalid=0 are allowed anywhere
isof  in  1  first byte of frame; qualified by ivalid
ieof  in  1  last byte of frame; qualified by ivalid
idata  in  8  frame byte; first byte is DA[47:40]
ipnum  in  $clog2(pNUM_PORTS)  ingress port; sampled with the isof byte
ovalid  out  1  request valid
iready  in  1  MAC table accepts the request
opnum  out  $clog2(pNUM_PORTS)  ingress port of the request
osa  out  pADDR_WIDTH  folded source index
oda  out  pADDR_WIDTH  folded destination index
omcast  out  1  DA I/G bit (DA[40]); table must flood rather than look up
odrop_cnt  out  pCNT_WIDTH  requests lost to backpressure, saturating
orunt_cnt  out  pCNT_WIDTH  frames ended before 12 bytes, saturating

Behaviour:
- Reset (async assert, sync deassert): ovalid=0, opnum/osa/oda/omcast=0, both counters=0, FSM=IDLE.
- FSM states:
  - IDLE: wait for ivalid&isof. On that byte, store it as DA byte 0, latch ipnum, set byte count=1, go to HDR.
  - HDR: shift in each ivalid byte into a 96-bit register (DA first, MSB first). Count bytes 0..11.
  - SKIP: ignore bytes until ivalid&ieof, then go to IDLE.
- HDR completion: when the 12th byte is accepted without ieof, go to SKIP. If the 12th byte carries ieof, go to IDLE.
- Result registration: on the cycle after the 12th byte, fold DA and SA into the result registers.
- Fold function: 48-bit address split into pADDR_WIDTH-bit chunks from bit 0 upward. The last chunk is zero-padded. All chunks are XORed. With the default, idx = a[13:0]^a[27:14]^a[41:28]^{8'b0,a[47:42]}.
- Latency: ovalid rises exactly 2 cycles after the cycle holding the 12th byte (1 cycle fold register, 1 cycle output register).
- Handshake: ovalid is held with stable opnum/osa/oda/omcast until the cycle where ovalid&iready; it drops the next cycle unless a new result loads.
  - A new result may load in the same cycle as the accept (back-to-back, no bubble).
  - The input stream has no backpressure. If a new result arrives while ovalid=1 and iready=0, the new result is discarded, the held request is kept, and odrop_cnt increments.
- Runt: ivalid&ieof while in HDR with fewer than 12 bytes accepted means no request, orunt_cnt increments, go to IDLE. A single byte with isof&ieof together is a runt.
- isof while in HDR or SKIP: the current frame is abandoned and capture restarts with this byte as DA byte 0. If abandoned in HDR, orunt_cnt increments.
- Bytes before the first isof after reset are ignored.
- Counters: saturate at all-ones and never wrap.
- Reset mid-frame or while ovalid=1: everything clears and the pending request is lost; the remainder of that frame is ignored until the next isof.

Decomposition:
- Package mac_pkg:
  - localparams MAC_BYTES=6 and HDR_BYTES=12.
  - typedef mac_t (logic [47:0]).
  - function mac_fold(mac_t, width) implementing the XOR fold. It is shared with the MAC table's own testbench model.
- One sub-module, sat_cnt (parameter width; inputs inc and clear; output count), instantiated twice for odrop_cnt and orunt_cnt.
- FSM, shift register and output register stay in mac_hdr_hash.

Test Plan:
- Frame on port 2, DA=00:00:00:00:00:01, SA=00:00:00:00:40:00, 64 bytes, iready=1 -> one request: opnum=2, oda=0x0001, osa=0x0001, omcast=0, ovalid high exactly 1 cycle, 2 cycles after byte 12.
- DA=FF:FF:FF:FF:FF:FF, SA=02:00:00:00:00:00, ivalid toggling every other cycle -> oda=0x3FC0, osa=0x2000, omcast=1.
- Frame ending with ieof on byte 7 -> no ovalid, orunt_cnt=1. Next good frame -> normal request.
- iready=0 held, two back-to-back 14-byte frames -> first request held stable with the first frame's values, odrop_cnt=1. Raise iready -> one handshake, ovalid=0 next cycle.
- isof reasserted at byte 5 of a frame -> orunt_cnt=1, request reflects the second frame's DA/SA only.
- irst_n pulsed low while ovalid=1 and mid-frame -> outputs and counters 0 immediately (async). Trailing bytes ignored, next isof frame handled normally.
